// File: rtl/fft_bfly_pkg.sv
// Shared types and twiddle-format helpers for the streaming FFT butterfly
// and its complex multiplier.
package fft_bfly_pkg;

    localparam int SAMPLE_W_DEF = 32;
    localparam int TWDL_W_DEF   = 10;

    typedef struct packed {
        logic signed [SAMPLE_W_DEF-1:0] re;
        logic signed [SAMPLE_W_DEF-1:0] im;
    } cplx_t;

    typedef enum logic {
        SEL_X0,
        SEL_X1
    } sel_state_t;

    // Twiddles are Q2.(TWDL_W-2): products are renormalised by TWDL_W-2 bits
    // with a half-LSB bias for round-half-up.
    function automatic int rnd_shift(input int twdl_w);
        return twdl_w - 2;
    endfunction

    function automatic int rnd_const(input int twdl_w);
        return 1 << (twdl_w - 3);
    endfunction

endpackage

// File: rtl/fft_cmult.sv
// Pipelined complex multiplier p = b*w with round-half-up renormalisation of
// the Q2 twiddle; LAT register stages with a matching valid pipe.
module fft_cmult
    import fft_bfly_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int TWDL_W   = TWDL_W_DEF,
    parameter int LAT      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic signed [SAMPLE_W-1:0] b_re,
    input  logic signed [SAMPLE_W-1:0] b_im,
    input  logic signed [TWDL_W-1:0]   w_re,
    input  logic signed [TWDL_W-1:0]   w_im,
    output logic                       out_vld,
    output logic signed [SAMPLE_W:0]   p_re,
    output logic signed [SAMPLE_W:0]   p_im
);

    localparam int PW = SAMPLE_W + TWDL_W + 2;
    localparam int RW = SAMPLE_W + 1;

    logic signed [PW-1:0] br, bi, wr, wi;
    logic signed [PW-1:0] full_re, full_im, rnd_re, rnd_im;
    logic signed [RW-1:0] pn_re, pn_im;

    always_comb begin
        br      = PW'(b_re);
        bi      = PW'(b_im);
        wr      = PW'(w_re);
        wi      = PW'(w_im);
        full_re = br * wr - bi * wi;
        full_im = br * wi + bi * wr;
        rnd_re  = full_re + PW'(rnd_const(TWDL_W));
        rnd_im  = full_im + PW'(rnd_const(TWDL_W));
        pn_re   = RW'(rnd_re >>> rnd_shift(TWDL_W));
        pn_im   = RW'(rnd_im >>> rnd_shift(TWDL_W));
    end

    logic signed [RW-1:0] re_pipe [LAT];
    logic signed [RW-1:0] im_pipe [LAT];
    logic        [LAT-1:0] vld_pipe;

    always_ff @(posedge clk) begin
        re_pipe[0] <= pn_re;
        im_pipe[0] <= pn_im;
        for (int i = 1; i < LAT; i++) begin
            re_pipe[i] <= re_pipe[i-1];
            im_pipe[i] <= im_pipe[i-1];
        end
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[LAT-1];
    assign p_re    = re_pipe[LAT-1];
    assign p_im    = im_pipe[LAT-1];

endmodule

// File: rtl/fft_bfly_stream.sv
// Streaming radix-2 butterfly: x0 = a + b*w, x1 = a - b*w as two output beats.
// Define FFT_BFLY_SAT_EN to clamp overflowing unscaled results instead of wrapping.
//
// state  | meaning
// SEL_X0 | head pair (if any) presents x0, out_last=0
// SEL_X1 | head pair presents x1, out_last=1; consume pops the pair
module fft_bfly_stream
    import fft_bfly_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int TWDL_W    = TWDL_W_DEF,
    parameter int MUL_LAT   = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] in_a_re,
    input  logic [SAMPLE_W-1:0] in_a_im,
    input  logic [SAMPLE_W-1:0] in_b_re,
    input  logic [SAMPLE_W-1:0] in_b_im,
    input  logic [TWDL_W-1:0]   in_w_re,
    input  logic [TWDL_W-1:0]   in_w_im,
    input  logic                in_inv,
    input  logic                in_scale,
    input  logic                in_vld,
    output logic                in_rdy,
    output logic [SAMPLE_W-1:0] out_re,
    output logic [SAMPLE_W-1:0] out_im,
    output logic                out_last,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                ovf_flag,
    input  logic                clr_ovf
);

    localparam int AW     = $clog2(OUT_DEPTH);
    localparam int CW     = $clog2(OUT_DEPTH + 1);
    localparam int PAIR_W = 4 * SAMPLE_W;
    localparam logic [TWDL_W-1:0] W_MIN = {1'b1, {(TWDL_W-1){1'b0}}};
    localparam logic [TWDL_W-1:0] W_MAX = {1'b0, {(TWDL_W-1){1'b1}}};

    logic              xfer;
    logic [TWDL_W-1:0] w_im_eff;

    assign xfer = in_vld & in_rdy;

    always_comb begin
        w_im_eff = in_w_im;
        if (in_inv) w_im_eff = (in_w_im == W_MIN) ? W_MAX : -in_w_im;
    end

    logic                p_vld;
    logic [SAMPLE_W:0]   p_re, p_im;

    fft_cmult #(
        .SAMPLE_W(SAMPLE_W),
        .TWDL_W  (TWDL_W),
        .LAT     (MUL_LAT)
    ) u_cmult (
        .clk    (clk),
        .rst    (rst),
        .in_vld (xfer),
        .b_re   (in_b_re),
        .b_im   (in_b_im),
        .w_re   (in_w_re),
        .w_im   (w_im_eff),
        .out_vld(p_vld),
        .p_re   (p_re),
        .p_im   (p_im)
    );

    logic [SAMPLE_W-1:0] a_re_pipe [MUL_LAT];
    logic [SAMPLE_W-1:0] a_im_pipe [MUL_LAT];
    logic [MUL_LAT-1:0]  scl_pipe;

    always_ff @(posedge clk) begin
        a_re_pipe[0] <= in_a_re;
        a_im_pipe[0] <= in_a_im;
        scl_pipe[0]  <= in_scale;
        for (int i = 1; i < MUL_LAT; i++) begin
            a_re_pipe[i] <= a_re_pipe[i-1];
            a_im_pipe[i] <= a_im_pipe[i-1];
            scl_pipe[i]  <= scl_pipe[i-1];
        end
    end

    function automatic void sum_comp(
        input  logic [SAMPLE_W-1:0] a,
        input  logic [SAMPLE_W:0]   p,
        input  logic                sub,
        input  logic                scl,
        output logic [SAMPLE_W-1:0] r,
        output logic                o
    );
        logic signed [SAMPLE_W+1:0] s;
        if (sub) s = $signed({{2{a[SAMPLE_W-1]}}, a}) - $signed({p[SAMPLE_W], p});
        else     s = $signed({{2{a[SAMPLE_W-1]}}, a}) + $signed({p[SAMPLE_W], p});
        o = 1'b0;
        if (scl) begin
            r = SAMPLE_W'(s >>> 1);
        end else begin
            r = SAMPLE_W'(s);
            o = (s[SAMPLE_W+1:SAMPLE_W-1] != 3'b000) && (s[SAMPLE_W+1:SAMPLE_W-1] != 3'b111);
`ifdef FFT_BFLY_SAT_EN
            if (o) r = s[SAMPLE_W+1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
`endif
        end
    endfunction

    logic [SAMPLE_W-1:0] x0_re, x0_im, x1_re, x1_im;
    logic                o0r, o0i, o1r, o1i, pair_ovf;

    always_comb begin
        sum_comp(a_re_pipe[MUL_LAT-1], p_re, 1'b0, scl_pipe[MUL_LAT-1], x0_re, o0r);
        sum_comp(a_im_pipe[MUL_LAT-1], p_im, 1'b0, scl_pipe[MUL_LAT-1], x0_im, o0i);
        sum_comp(a_re_pipe[MUL_LAT-1], p_re, 1'b1, scl_pipe[MUL_LAT-1], x1_re, o1r);
        sum_comp(a_im_pipe[MUL_LAT-1], p_im, 1'b1, scl_pipe[MUL_LAT-1], x1_im, o1i);
        pair_ovf = o0r | o0i | o1r | o1i;
    end

    // Pair FIFO plus a head register that feeds the serializer directly.
    logic [PAIR_W-1:0] mem [OUT_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     mem_cnt;
    logic [PAIR_W-1:0] hd;
    logic              hd_vld, hd_load, x1_pop, consume;

    assign hd_load = (mem_cnt != '0) & (~hd_vld | x1_pop);

    always_ff @(posedge clk) begin
        if (p_vld) mem[wr_ptr] <= {x0_re, x0_im, x1_re, x1_im};
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            hd       <= '0;
            hd_vld   <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (p_vld)   wr_ptr <= wr_ptr + AW'(1);
            if (hd_load) begin
                rd_ptr <= rd_ptr + AW'(1);
                hd     <= mem[rd_ptr];
            end
            mem_cnt  <= mem_cnt + CW'(p_vld) - CW'(hd_load);
            hd_vld   <= hd_load | (hd_vld & ~x1_pop);
            ovf_flag <= (p_vld & pair_ovf) | (ovf_flag & ~clr_ovf);
        end
    end

    sel_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= SEL_X0;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        out_vld  = hd_vld;
        consume  = hd_vld & out_rdy;
        x1_pop   = 1'b0;
        out_last = 1'b0;
        out_re   = hd[4*SAMPLE_W-1 -: SAMPLE_W];
        out_im   = hd[3*SAMPLE_W-1 -: SAMPLE_W];
        case (state_q)
            SEL_X0: begin
                if (consume) state_d = SEL_X1;
            end
            SEL_X1: begin
                out_re   = hd[2*SAMPLE_W-1 -: SAMPLE_W];
                out_im   = hd[SAMPLE_W-1:0];
                out_last = hd_vld;
                x1_pop   = consume;
                if (consume) state_d = SEL_X0;
            end
            default: state_d = SEL_X0;
        endcase
    end

    // Credits cover every pair from acceptance until its x1 beat leaves.
    logic [CW-1:0] occ, occ_next;
    logic          rdy_q;

    assign occ_next = occ + CW'(xfer) - CW'(x1_pop);
    assign in_rdy   = rdy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= '0;
            rdy_q <= 1'b0;
        end else begin
            occ   <= occ_next;
            rdy_q <= (occ_next < CW'(OUT_DEPTH));
        end
    end

endmodule

// File: tb/tb_fft_bfly_stream.sv
// Self-checking bench for fft_bfly_stream: directed vectors plus randomized
// traffic against an arithmetic reference model.
module tb_fft_bfly_stream;

    localparam int SW = 32;
    localparam int TW = 10;
    localparam int ML = 3;
    localparam int OD = 4;

    logic          clk, rst;
    logic [SW-1:0] in_a_re, in_a_im, in_b_re, in_b_im;
    logic [TW-1:0] in_w_re, in_w_im;
    logic          in_inv, in_scale, in_vld, in_rdy;
    logic [SW-1:0] out_re, out_im;
    logic          out_last, out_vld, out_rdy, ovf_flag, clr_ovf;

    fft_bfly_stream #(
        .SAMPLE_W (SW),
        .TWDL_W   (TW),
        .MUL_LAT  (ML),
        .OUT_DEPTH(OD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_a_re (in_a_re),
        .in_a_im (in_a_im),
        .in_b_re (in_b_re),
        .in_b_im (in_b_im),
        .in_w_re (in_w_re),
        .in_w_im (in_w_im),
        .in_inv  (in_inv),
        .in_scale(in_scale),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .out_re  (out_re),
        .out_im  (out_im),
        .out_last(out_last),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .ovf_flag(ovf_flag),
        .clr_ovf (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] re;
        logic [SW-1:0] im;
        bit            last;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_ovf;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint trunc_pn(input longint v);
        logic signed [SW:0] t;
        t = v[SW:0];
        return longint'(t);
    endfunction

    function automatic void comp(input longint s, input bit scl,
                                 output logic [SW-1:0] r, output bit o);
        longint maxv, minv, h;
        maxv = (longint'(1) <<< (SW-1)) - 1;
        minv = -(longint'(1) <<< (SW-1));
        o = 1'b0;
        if (scl) begin
            h = s >>> 1;
            r = h[SW-1:0];
        end else begin
            r = s[SW-1:0];
            o = (s > maxv) || (s < minv);
`ifdef FFT_BFLY_SAT_EN
            if (o) begin
                h = (s < 0) ? minv : maxv;
                r = h[SW-1:0];
            end
`endif
        end
    endfunction

    function automatic void model_pair(
        input  logic [SW-1:0] ar, ai, br, bi,
        input  logic [TW-1:0] wr, wi,
        input  bit inv, scl,
        output logic [SW-1:0] x0r, x0i, x1r, x1i,
        output bit ovf);
        longint a_r, a_i, b_r, b_i, w_r, w_i, pr, pi, half;
        bit o0, o1, o2, o3;
        a_r = longint'($signed(ar));
        a_i = longint'($signed(ai));
        b_r = longint'($signed(br));
        b_i = longint'($signed(bi));
        w_r = longint'($signed(wr));
        w_i = longint'($signed(wi));
        if (inv) w_i = (w_i == -(longint'(1) <<< (TW-1))) ? (longint'(1) <<< (TW-1)) - 1 : -w_i;
        half = longint'(1) <<< (TW-3);
        pr = trunc_pn((b_r * w_r - b_i * w_i + half) >>> (TW-2));
        pi = trunc_pn((b_r * w_i + b_i * w_r + half) >>> (TW-2));
        comp(a_r + pr, scl, x0r, o0);
        comp(a_i + pi, scl, x0i, o1);
        comp(a_r - pr, scl, x1r, o2);
        comp(a_i - pi, scl, x1i, o3);
        ovf = o0 | o1 | o2 | o3;
    endfunction

    task automatic push_pair();
        logic [SW-1:0] x0r, x0i, x1r, x1i;
        bit o;
        model_pair(in_a_re, in_a_im, in_b_re, in_b_im, in_w_re, in_w_im, in_inv, in_scale,
                   x0r, x0i, x1r, x1i, o);
        exp_q.push_back('{x0r, x0i, 1'b0});
        exp_q.push_back('{x1r, x1i, 1'b1});
        exp_ovf |= o;
    endtask

    task automatic rand_inputs();
        in_a_re  = $urandom;
        in_a_im  = $urandom;
        in_b_re  = $urandom;
        in_b_im  = $urandom;
        in_w_re  = TW'($urandom);
        in_w_im  = TW'($urandom);
        in_inv   = 1'($urandom);
        in_scale = 1'($urandom);
    endtask

    task automatic check_beat(input string name);
        beat_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: unexpected beat re=%h im=%h last=%0b", name, out_re, out_im, out_last);
        end else begin
            e = exp_q.pop_front();
            if (out_re !== e.re || out_im !== e.im || out_last !== e.last) begin
                n_errors++;
                $display("FAIL %s: got re=%h im=%h last=%0b want re=%h im=%h last=%0b",
                         name, out_re, out_im, out_last, e.re, e.im, e.last);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0 || out_last !== 1'b0 || ovf_flag !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b ovf=%b want 0 0 0 0",
                     in_rdy, out_vld, out_last, ovf_flag);
        end
        n_checks++;
        if (out_re !== '0 || out_im !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got re=%h im=%h want 0 0", out_re, out_im);
        end
        rst = 1'b0;
        n_checks++;
        if (in_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_rdy_early: got %b want 0", in_rdy);
        end
        tick();
        n_checks++;
        if (in_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_rdy_rise: got %b want 1", in_rdy);
        end
    endtask

    task automatic send_check(input string name,
                              input logic [SW-1:0] ar, ai, br, bi,
                              input logic [TW-1:0] wr, wi, input bit inv, scl,
                              input logic [SW-1:0] e0r, e0i, e1r, e1i);
        int k;
        in_a_re = ar; in_a_im = ai; in_b_re = br; in_b_im = bi;
        in_w_re = wr; in_w_im = wi; in_inv = inv; in_scale = scl;
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        for (int i = 0; i < 50 && !in_rdy; i++) tick();
        tick();
        in_vld = 1'b0;
        k = 1;
        while (!out_vld && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (k != ML + 2) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, k, ML + 2);
        end
        n_checks++;
        if (out_vld !== 1'b1 || out_re !== e0r || out_im !== e0i || out_last !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_x0: got vld=%b re=%h im=%h last=%b want 1 %h %h 0",
                     name, out_vld, out_re, out_im, out_last, e0r, e0i);
        end
        tick();
        n_checks++;
        if (out_vld !== 1'b1 || out_re !== e1r || out_im !== e1i || out_last !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_x1: got vld=%b re=%h im=%h last=%b want 1 %h %h 1",
                     name, out_vld, out_re, out_im, out_last, e1r, e1i);
        end
        tick();
        n_checks++;
        if (out_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_idle: got vld=%b want 0", name, out_vld);
        end
    endtask

    task automatic test_basic();
        send_check("fwd", 100, -50, 40, 8, 256, 0, 1'b0, 1'b0, 140, -42, 60, -58);
        send_check("inv", 100, -50, 40, 8, 0, 256, 1'b1, 1'b0, 108, -90, 92, -10);
    endtask

    task automatic test_scale_ovf();
        logic [SW-1:0] sat_x0;
`ifdef FFT_BFLY_SAT_EN
        sat_x0 = 32'h7fff_ffff;
`else
        sat_x0 = 32'h8000_0000;
`endif
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        send_check("scaled", 32'h7fff_ffff, 0, 1, 0, 256, 0, 1'b0, 1'b1,
                   32'h4000_0000, 0, 32'h3fff_ffff, 0);
        n_checks++;
        if (ovf_flag !== 1'b0) begin
            n_errors++;
            $display("FAIL scaled_ovf: got %b want 0", ovf_flag);
        end
        send_check("wrap", 32'h7fff_ffff, 0, 1, 0, 256, 0, 1'b0, 1'b0,
                   sat_x0, 0, 32'h7fff_fffe, 0);
        n_checks++;
        if (ovf_flag !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_ovf: got %b want 1", ovf_flag);
        end
    endtask

    task automatic test_ovf_clr();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_checks++;
        if (ovf_flag !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: got %b want 0", ovf_flag);
        end
        in_a_re = 32'h7fff_ffff; in_a_im = 0; in_b_re = 1; in_b_im = 0;
        in_w_re = 256; in_w_im = 0; in_inv = 1'b0; in_scale = 1'b0;
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        for (int i = 0; i < 50 && !in_rdy; i++) tick();
        tick();
        in_vld  = 1'b0;
        clr_ovf = 1'b1;
        repeat (ML) tick();
        clr_ovf = 1'b0;
        n_checks++;
        if (ovf_flag !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_set_wins: got %b want 1", ovf_flag);
        end
        repeat (ML + 6) tick();
    endtask

    task automatic test_backpressure();
        int acc, beats;
        exp_q.delete();
        acc = 0;
        out_rdy = 1'b0;
        for (int c = 0; c < 3 * OD + ML + 6; c++) begin
            rand_inputs();
            in_vld = 1'b1;
            if (in_rdy) begin
                push_pair();
                acc++;
            end
            tick();
        end
        in_vld = 1'b0;
        n_checks++;
        if (acc != OD || in_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_accept: got %0d transfers rdy=%b want %0d rdy=0", acc, in_rdy, OD);
        end
        out_rdy = 1'b1;
        beats = 0;
        for (int c = 0; c < 4 * OD + 10; c++) begin
            if (out_vld) begin
                check_beat("bp_beat");
                beats++;
            end
            tick();
        end
        n_checks++;
        if (beats != 2 * OD || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL bp_count: got %0d beats want %0d", beats, 2 * OD);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        out_rdy = 1'b1;
        rand_inputs();
        in_vld = 1'b1;
        tick();
        rand_inputs();
        tick();
        in_vld = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0 || ovf_flag !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_state: got rdy=%b vld=%b ovf=%b want 0 0 0", in_rdy, out_vld, ovf_flag);
        end
        tick();
        n_checks++;
        if (in_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_rdy: got %b want 1", in_rdy);
        end
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_vld) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL midrst_flush: got %0d valid beats want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int sent, cyc;
        bit held;
        logic [SW-1:0] h_re, h_im;
        logic h_last;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        exp_q.delete();
        sent = 0;
        cyc  = 0;
        held = 1'b0;
        h_re = '0; h_im = '0; h_last = 1'b0;
        while ((sent < 2000 || exp_q.size() != 0) && cyc < 20000) begin
            if (held) begin
                n_checks++;
                if (out_vld !== 1'b1 || out_re !== h_re || out_im !== h_im || out_last !== h_last) begin
                    n_errors++;
                    $display("FAIL hold: got vld=%b re=%h im=%h last=%b want 1 %h %h %b",
                             out_vld, out_re, out_im, out_last, h_re, h_im, h_last);
                end
            end
            rand_inputs();
            in_vld  = (sent < 2000) && ($urandom_range(0, 9) < 8);
            out_rdy = ($urandom_range(0, 9) < 7);
            if (in_vld && in_rdy) begin
                push_pair();
                sent++;
            end
            held = out_vld && !out_rdy;
            h_re = out_re; h_im = out_im; h_last = out_last;
            if (out_vld && out_rdy) check_beat("rand_beat");
            tick();
            cyc++;
        end
        in_vld = 1'b0;
        n_checks++;
        if (cyc >= 20000) begin
            n_errors++;
            $display("FAIL rand_timeout: sent %0d pending %0d", sent, exp_q.size());
        end
        n_checks++;
        if (ovf_flag !== exp_ovf) begin
            n_errors++;
            $display("FAIL rand_ovf: got %b want %b", ovf_flag, exp_ovf);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_vld = 1'b0; out_rdy = 1'b0; clr_ovf = 1'b0;
        in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
        in_w_re = '0; in_w_im = '0; in_inv = 1'b0; in_scale = 1'b0;
        exp_ovf = 1'b0;
        test_reset();
        test_basic();
        test_scale_ovf();
        test_ovf_clr();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
